// File: rtl/ad9517_spi_pkg.sv
// rtl/ad9517_spi_pkg.sv - AD9517 serial port header fields, byte-count codes and FSM states
package ad9517_spi_pkg;

  localparam int HDR_RW_BIT   = 15;
  localparam int HDR_W_MSB    = 14;
  localparam int HDR_W_LSB    = 13;
  localparam int HDR_ADDR_MSB = 12;

  localparam logic [1:0] W_ONE    = 2'b00;
  localparam logic [1:0] W_TWO    = 2'b01;
  localparam logic [1:0] W_THREE  = 2'b10;
  localparam logic [1:0] W_STREAM = 2'b11;

  localparam logic [12:0] ADDR_PART_ID = 13'h003;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INSTR,
    ST_WDATA,
    ST_RDATA,
    ST_DONE
  } spi_state_t;

endpackage

// File: rtl/ad9517_spi_if.sv
// rtl/ad9517_spi_if.sv - 3-wire SPI pin bundle (SDIO split into sdi/sdo/sdo_oe at the IOBUF)
interface ad9517_spi_if;
  logic sclk_in;
  logic cs_n_in;
  logic sdi;
  logic sdo;
  logic sdo_oe;

  modport master (output sclk_in, output cs_n_in, output sdi, input sdo, input sdo_oe);
  modport slave  (input sclk_in, input cs_n_in, input sdi, output sdo, output sdo_oe);
endinterface

// File: rtl/spi_in_sync_edge.sv
// rtl/spi_in_sync_edge.sv - N-stage input synchronizer with single-cycle rise/fall pulses
module spi_in_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync <= {STAGES{RESET_VAL}};
      last <= RESET_VAL;
    end else begin
      sync[0] <= d;
      for (int i = 1; i < STAGES; i++) sync[i] <= sync[i-1];
      last <= sync[STAGES-1];
    end
  end

  assign rise = sync[STAGES-1] & ~last;
  assign fall = ~sync[STAGES-1] & last;

endmodule

// File: rtl/ad9517_spi_slave.sv
// rtl/ad9517_spi_slave.sv - AD9517 3-wire serial control port responder with byte register file
module ad9517_spi_slave
  import ad9517_spi_pkg::*;
#(
  parameter int         REG_DEPTH   = 256,
  parameter logic [7:0] PART_ID     = 8'h51,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rstn,
  ad9517_spi_if.slave       spi,
  output logic              reg_wr_en,
  output logic [12:0]       reg_wr_addr,
  output logic [7:0]        reg_wr_data,
  output logic              busy,
  output logic              xfer_done
);

  localparam int          AW        = $clog2(REG_DEPTH);
  localparam logic [13:0] DEPTH_LIM = 14'(REG_DEPTH);

  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic                   sdi_s;

  // CS_N idles high so reset release never looks like a frame start
  spi_in_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rstn(rstn), .d(spi.sclk_in), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_in_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rstn(rstn), .d(spi.cs_n_in), .rise(cs_rise), .fall(cs_fall)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sdi_sync <= '0;
    end else begin
      sdi_sync[0] <= spi.sdi;
      for (int i = 1; i < SYNC_STAGES; i++) sdi_sync[i] <= sdi_sync[i-1];
    end
  end
  assign sdi_s = sdi_sync[SYNC_STAGES-1];

  spi_state_t  state;
  logic [3:0]  bit_cnt;
  logic [14:0] shreg;
  logic [12:0] addr;
  logic [1:0]  bytes_left;
  logic        stream;
  logic [15:0] shift_word;
  logic [7:0]  regs [REG_DEPTH];
  logic [7:0]  rd_byte;
  logic        in_range, is_id, wr_ok, wr_commit, byte_end;

  assign shift_word = {shreg, sdi_s};
  assign in_range   = ({1'b0, addr} < DEPTH_LIM);
  assign is_id      = (addr == ADDR_PART_ID);
  assign wr_ok      = in_range & ~is_id;
  assign byte_end   = sclk_rise && (bit_cnt == 4'd7) && !cs_rise && !cs_fall;
  assign wr_commit  = (state == ST_WDATA) && byte_end && wr_ok;

  always_comb begin
    rd_byte = 8'h00;
    if (is_id)         rd_byte = PART_ID;
    else if (in_range) rd_byte = regs[addr[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < REG_DEPTH; i++) regs[i] <= 8'h00;
    end else if (wr_commit) begin
      regs[addr[AW-1:0]] <= shift_word[7:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      addr        <= '0;
      bytes_left  <= '0;
      stream      <= 1'b0;
      spi.sdo     <= 1'b0;
      spi.sdo_oe  <= 1'b0;
      reg_wr_en   <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      busy        <= 1'b0;
      xfer_done   <= 1'b0;
    end else begin
      reg_wr_en <= 1'b0;
      xfer_done <= cs_rise;
      if (cs_rise) begin
        state      <= ST_IDLE;
        spi.sdo    <= 1'b0;
        spi.sdo_oe <= 1'b0;
        busy       <= 1'b0;
      end else if (cs_fall) begin
        state   <= ST_INSTR;
        bit_cnt <= '0;
        busy    <= 1'b1;
      end else begin
        unique case (state)
          ST_INSTR: begin
            if (sclk_rise) begin
              shreg   <= shift_word[14:0];
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd15) begin
                state      <= shift_word[HDR_RW_BIT] ? ST_RDATA : ST_WDATA;
                addr       <= shift_word[HDR_ADDR_MSB:0];
                bytes_left <= shift_word[HDR_W_MSB:HDR_W_LSB];
                stream     <= (shift_word[HDR_W_MSB:HDR_W_LSB] == W_STREAM);
              end
            end
          end
          ST_WDATA: begin
            if (sclk_rise) begin
              shreg   <= shift_word[14:0];
              bit_cnt <= bit_cnt + 4'd1;
            end
            if (wr_commit) begin
              reg_wr_en   <= 1'b1;
              reg_wr_addr <= addr;
              reg_wr_data <= shift_word[7:0];
            end
            if (byte_end) begin
              bit_cnt <= '0;
              addr    <= addr - 13'd1;
              if (!stream) begin
                if (bytes_left == 2'd0) state <= ST_DONE;
                else                    bytes_left <= bytes_left - 2'd1;
              end
            end
          end
          ST_RDATA: begin
            // bit_cnt counts rising edges; a fall with bit_cnt == 0 starts a new byte
            if (sclk_fall) begin
              spi.sdo_oe <= 1'b1;
              if (bit_cnt == 4'd0) begin
                spi.sdo    <= rd_byte[7];
                shreg[7:0] <= {rd_byte[6:0], 1'b0};
              end else begin
                spi.sdo    <= shreg[7];
                shreg[7:0] <= {shreg[6:0], 1'b0};
              end
            end else if (sclk_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end
            if (byte_end) begin
              bit_cnt <= '0;
              addr    <= addr - 13'd1;
              if (!stream) begin
                if (bytes_left == 2'd0) begin
                  state      <= ST_DONE;
                  spi.sdo    <= 1'b0;
                  spi.sdo_oe <= 1'b0;
                end else begin
                  bytes_left <= bytes_left - 2'd1;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ad9517_spi_slave.sv
// tb/tb_ad9517_spi_slave.sv - directed self-checking bench for ad9517_spi_slave
module tb_ad9517_spi_slave;

  localparam int HALF = 8;

  logic        clk;
  logic        rstn;
  logic        reg_wr_en;
  logic [12:0] reg_wr_addr;
  logic [7:0]  reg_wr_data;
  logic        busy;
  logic        xfer_done;

  ad9517_spi_if spi ();

  ad9517_spi_slave dut (
    .clk(clk), .rstn(rstn), .spi(spi),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .busy(busy), .xfer_done(xfer_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  logic [12:0] wl_addr [32];
  logic [7:0]  wl_data [32];
  logic [7:0]  tx_bytes [4];
  logic [7:0]  rx_bytes [4];
  logic        hdr_oe;
  logic        busy_mid;
  int          data_oe;
  int          w0, d0;

  always @(negedge clk) begin
    if (reg_wr_en === 1'b1) begin
      if (wr_cnt < 32) begin
        wl_addr[wr_cnt] = reg_wr_addr;
        wl_data[wr_cnt] = reg_wr_data;
      end
      wr_cnt++;
    end
    if (xfer_done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_cycle(input logic b, output logic r, output logic oe);
    @(negedge clk);
    spi.sdi = b;
    repeat (HALF - 1) @(negedge clk);
    spi.sclk_in = 1'b1;
    r  = spi.sdo;
    oe = spi.sdo_oe;
    repeat (HALF) @(negedge clk);
    spi.sclk_in = 1'b0;
  endtask

  task automatic xfer(input logic [15:0] hdr, input int nbits, input bit keep_cs);
    logic r, o;
    hdr_oe   = 1'b0;
    busy_mid = 1'b0;
    data_oe  = 0;
    @(negedge clk);
    spi.cs_n_in = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 15; i >= 0; i--) begin
      bit_cycle(hdr[i], r, o);
      hdr_oe = hdr_oe | o;
      if (i == 8) busy_mid = busy;
    end
    if (hdr[15]) begin
      repeat (2) @(negedge clk);
      check("oe_latency_early", spi.sdo_oe, 1'b0);
      @(negedge clk);
      check("oe_latency", spi.sdo_oe, 1'b1);
    end
    for (int i = 0; i < nbits; i++) begin
      bit_cycle(tx_bytes[i/8][7-(i%8)], r, o);
      rx_bytes[i/8][7-(i%8)] = r;
      if (o) data_oe++;
    end
    if (!keep_cs) begin
      repeat (HALF) @(negedge clk);
      spi.cs_n_in = 1'b1;
      repeat (3 * HALF) @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    spi.cs_n_in = 1'b1;
    spi.sclk_in = 1'b0;
    spi.sdi = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_outputs", {spi.sdo, spi.sdo_oe, reg_wr_en, reg_wr_addr, reg_wr_data, busy, xfer_done}, 0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    // single-byte write 0x010 = 0xA5
    w0 = wr_cnt; d0 = done_cnt;
    tx_bytes[0] = 8'hA5;
    xfer(16'h0010, 8, 0);
    check("wr10_count", wr_cnt - w0, 1);
    check("wr10_addr", wl_addr[w0], 13'h010);
    check("wr10_data", wl_data[w0], 8'hA5);
    check("wr10_busy_mid", busy_mid, 1'b1);
    check("wr10_done", done_cnt - d0, 1);
    check("wr10_busy_after", busy, 1'b0);

    // read 0x010
    xfer(16'h8010, 8, 0);
    check("rd10_data", rx_bytes[0], 8'hA5);
    check("rd10_oe_bits", data_oe, 8);
    check("rd10_hdr_oe", hdr_oe, 1'b0);
    check("rd10_oe_after", spi.sdo_oe, 1'b0);

    // part id read, write ignored, re-read
    xfer(16'h8003, 8, 0);
    check("rd03_data", rx_bytes[0], 8'h51);
    w0 = wr_cnt;
    tx_bytes[0] = 8'hFF;
    xfer(16'h0003, 8, 0);
    check("wr03_no_pulse", wr_cnt - w0, 0);
    xfer(16'h8003, 8, 0);
    check("rd03_again", rx_bytes[0], 8'h51);

    // streaming write at 0x012, descending addresses
    w0 = wr_cnt;
    tx_bytes[0] = 8'h11; tx_bytes[1] = 8'h22; tx_bytes[2] = 8'h33;
    xfer(16'h6012, 24, 0);
    check("stream_count", wr_cnt - w0, 3);
    check("stream_a0", {wl_addr[w0], wl_data[w0]}, {13'h012, 8'h11});
    check("stream_a1", {wl_addr[w0+1], wl_data[w0+1]}, {13'h011, 8'h22});
    check("stream_a2", {wl_addr[w0+2], wl_data[w0+2]}, {13'h010, 8'h33});
    xfer(16'hC012, 24, 0);
    check("rd3_b0", rx_bytes[0], 8'h11);
    check("rd3_b1", rx_bytes[1], 8'h22);
    check("rd3_b2", rx_bytes[2], 8'h33);
    check("rd3_oe_bits", data_oe, 24);

    // aborted write after 4 data bits keeps the old value
    tx_bytes[0] = 8'h3C;
    xfer(16'h0020, 8, 0);
    w0 = wr_cnt;
    tx_bytes[0] = 8'hC3;
    xfer(16'h0020, 4, 0);
    check("abort_no_pulse", wr_cnt - w0, 0);
    xfer(16'h8020, 8, 0);
    check("abort_keeps", rx_bytes[0], 8'h3C);

    // out-of-range address
    xfer(16'h8100, 8, 0);
    check("rd100_data", rx_bytes[0], 8'h00);
    w0 = wr_cnt;
    tx_bytes[0] = 8'h77;
    xfer(16'h0100, 8, 0);
    check("wr100_no_pulse", wr_cnt - w0, 0);

    // reset in the middle of a read
    xfer(16'h8010, 4, 1);
    check("midread_oe", spi.sdo_oe, 1'b1);
    check("midread_busy", busy, 1'b1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("midread_reset_outputs", {spi.sdo, spi.sdo_oe, reg_wr_en, reg_wr_addr, reg_wr_data, busy, xfer_done}, 0);
    spi.cs_n_in = 1'b1;
    spi.sclk_in = 1'b0;
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    xfer(16'h8010, 8, 0);
    check("post_reset_rd10", rx_bytes[0], 8'h00);
    xfer(16'h8012, 8, 0);
    check("post_reset_rd12", rx_bytes[0], 8'h00);
    xfer(16'h8003, 8, 0);
    check("post_reset_rd03", rx_bytes[0], 8'h51);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
